// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and constants for the elevator floor scheduler.
//               Holds the direction FSM state type and the encoding of the
//               travel direction output.
// Revision    : 1.0  initial release
// ============================================================================
package elevator_pkg;

    // Direction FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_state_t;

    // Encoding of the dir output
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/floor_seek.sv
`default_nettype none
// ============================================================================
// Module      : floor_seek
// Description : Purely combinational SCAN seek. From the pending-request
//               vector and the car position, finds the nearest request at or
//               above the car and the nearest request at or below the car.
//               A request at the car's own floor counts for both searches.
// Revision    : 1.0  initial release
//
// Ports
//   req        in   NUM_FLOORS  pending requests, bit i = floor i
//   cur_floor  in   FLOOR_W     current car position
//   above      out  FLOOR_W     lowest i >= cur_floor with req[i]
//   above_hit  out  1           above is valid
//   below      out  FLOOR_W     highest i <= cur_floor with req[i]
//   below_hit  out  1           below is valid
// ============================================================================
module floor_seek #(
    parameter int NUM_FLOORS = 4,
    localparam int FLOOR_W   = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    above,
    output logic                  above_hit,
    output logic [FLOOR_W-1:0]    below,
    output logic                  below_hit
);

    // Upward search walks from the top down so the last match written is the
    // lowest qualifying floor.
    always_comb begin
        above     = '0;
        above_hit = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (req[i] && (FLOOR_W'(i) >= cur_floor)) begin
                above     = FLOOR_W'(i);
                above_hit = 1'b1;
            end
        end
    end

    // Downward search walks from the bottom up so the last match written is
    // the highest qualifying floor. An out-of-range cur_floor (non power of
    // two floor count) simply sees every floor as below.
    always_comb begin
        below     = '0;
        below_hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (FLOOR_W'(i) <= cur_floor)) begin
                below     = FLOOR_W'(i);
                below_hit = 1'b1;
            end
        end
    end

endmodule : floor_seek
`default_nettype wire

// File: rtl/floor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : floor_scheduler
// Description : Request latch and SCAN scheduler for an N-floor elevator.
//               Latches one pending request per floor, clears it when the
//               car reports service, tracks the travel direction and presents
//               the next stop in that direction.
// Revision    : 1.0  initial release
//
// Ports
//   Clock         in   1           system clock, rising edge
//   Reset         in   1           synchronous active-high reset
//   KEY           in   NUM_FLOORS  level-sensitive request buttons
//   Done          in   1           car has serviced cur_floor (1-cycle pulse)
//   cur_floor     in   FLOOR_W     current car position
//   floor         out  NUM_FLOORS  latched pending requests
//   target        out  FLOOR_W     next stop (valid when target_valid)
//   target_valid  out  1           a stop exists in the travel direction
//   dir           out  1           1 = up, 0 = down; held while idle
// ============================================================================
module floor_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    localparam int FLOOR_W   = $clog2(NUM_FLOORS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] KEY,
    input  logic                  Done,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] floor,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_valid,
    output logic                  dir
);

    logic [NUM_FLOORS-1:0] r_req;
    logic [NUM_FLOORS-1:0] w_req_next;
    dir_state_t            r_state;
    dir_state_t            w_state_next;
    logic                  r_dir;

    logic [FLOOR_W-1:0]    w_above;
    logic                  w_above_hit;
    logic [FLOOR_W-1:0]    w_below;
    logic                  w_below_hit;
    logic                  w_any_req;

    // ------------------------------------------------------------------------
    // Request register: service clear beats a simultaneous key press; a key
    // still held re-latches on the following edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_next = r_req;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (Done && (cur_floor == FLOOR_W'(i))) begin
                w_req_next[i] = 1'b0;
            end else if (KEY[i]) begin
                w_req_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_req <= '0;
        end else begin
            r_req <= w_req_next;
        end
    end

    assign floor     = r_req;
    assign w_any_req = |r_req;

    // ------------------------------------------------------------------------
    // Seek terms from the registered requests
    // ------------------------------------------------------------------------
    floor_seek #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_floor_seek (
        .req       (r_req),
        .cur_floor (cur_floor),
        .above     (w_above),
        .above_hit (w_above_hit),
        .below     (w_below),
        .below_hit (w_below_hit)
    );

    // ------------------------------------------------------------------------
    // Direction FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_above_hit)    w_state_next = UP;
                else if (w_any_req) w_state_next = DOWN;
                else                w_state_next = IDLE;
            end
            UP: begin
                if (w_above_hit)    w_state_next = UP;
                else if (w_any_req) w_state_next = DOWN;
                else                w_state_next = IDLE;
            end
            DOWN: begin
                if (w_below_hit)    w_state_next = DOWN;
                else if (w_any_req) w_state_next = UP;
                else                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Direction only changes on entry into UP or DOWN, so it keeps the last
    // travel direction through IDLE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_dir <= DIR_UP;
        end else if ((w_state_next == UP) && (r_state != UP)) begin
            r_dir <= DIR_UP;
        end else if ((w_state_next == DOWN) && (r_state != DOWN)) begin
            r_dir <= DIR_DOWN;
        end
    end

    assign dir = r_dir;

    // Target follows cur_floor combinationally so the consumer always sees
    // the nearest stop for the car's present position.
    always_comb begin
        target       = '0;
        target_valid = 1'b0;
        unique case (r_state)
            UP: begin
                target       = w_above;
                target_valid = w_above_hit;
            end
            DOWN: begin
                target       = w_below;
                target_valid = w_below_hit;
            end
            default: begin
                target       = '0;
                target_valid = 1'b0;
            end
        endcase
    end

endmodule : floor_scheduler
`default_nettype wire

// File: tb/tb_floor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_scheduler
// Description : Directed self-checking bench for floor_scheduler, with a
//               4-floor instance and a 3-floor instance sharing clock/reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_floor_scheduler;

    logic       clk;
    logic       rst;

    // 4-floor instance
    logic [3:0] key;
    logic       done;
    logic [1:0] cur;
    logic [3:0] floor4;
    logic [1:0] target4;
    logic       tv4;
    logic       dir4;

    // 3-floor instance
    logic [2:0] key3;
    logic       done3;
    logic [1:0] cur3;
    logic [2:0] floor3;
    logic [1:0] target3;
    logic       tv3;
    logic       dir3;

    int n_cmp;
    int n_err;

    floor_scheduler #(.NUM_FLOORS(4)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .KEY          (key),
        .Done         (done),
        .cur_floor    (cur),
        .floor        (floor4),
        .target       (target4),
        .target_valid (tv4),
        .dir          (dir4)
    );

    floor_scheduler #(.NUM_FLOORS(3)) dut3 (
        .Clock        (clk),
        .Reset        (rst),
        .KEY          (key3),
        .Done         (done3),
        .cur_floor    (cur3),
        .floor        (floor3),
        .target       (target3),
        .target_valid (tv3),
        .dir          (dir3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 4'b1111; done = 1'b0; cur = 2'd0;
        key3 = 3'b111; done3 = 1'b0; cur3 = 2'd0;
        tick(); tick();
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL reset_floor: got %b expected 0000", floor4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL reset_tv: got %b expected 0", tv4); end
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b expected 1", dir4); end
        n_cmp++; if (target4 !== 2'd0) begin n_err++; $display("FAIL reset_target: got %0d expected 0", target4); end
        n_cmp++; if (floor3 !== 3'b000) begin n_err++; $display("FAIL reset_floor3: got %b expected 000", floor3); end
        rst = 1'b0; key = 4'b0000; key3 = 3'b000;
        tick();
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL post_reset_floor: got %b expected 0000", floor4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL post_reset_tv: got %b expected 0", tv4); end
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL post_reset_dir: got %b expected 1", dir4); end
    endtask

    task automatic test_single_key();
        cur = 2'd0; key = 4'b0100;
        tick();
        key = 4'b0000;
        n_cmp++; if (floor4 !== 4'b0100) begin n_err++; $display("FAIL key_latch: got %b expected 0100", floor4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL key_tv_early: got %b expected 0", tv4); end
        tick();
        n_cmp++; if (target4 !== 2'd2) begin n_err++; $display("FAIL key_target: got %0d expected 2", target4); end
        n_cmp++; if (tv4 !== 1'b1) begin n_err++; $display("FAIL key_tv: got %b expected 1", tv4); end
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL key_dir: got %b expected 1", dir4); end
        cur = 2'd2; done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL key_served: got %b expected 0000", floor4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL key_served_tv: got %b expected 0", tv4); end
        tick();
    endtask

    task automatic test_scan_reverse();
        cur = 2'd2; key = 4'b1010;
        tick();
        key = 4'b0000;
        tick();
        n_cmp++; if (target4 !== 2'd3) begin n_err++; $display("FAIL scan_up_target: got %0d expected 3", target4); end
        n_cmp++; if (tv4 !== 1'b1) begin n_err++; $display("FAIL scan_up_tv: got %b expected 1", tv4); end
        cur = 2'd3; done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (floor4 !== 4'b0010) begin n_err++; $display("FAIL scan_done3: got %b expected 0010", floor4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL scan_gap_tv: got %b expected 0", tv4); end
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL scan_gap_dir: got %b expected 1", dir4); end
        tick();
        n_cmp++; if (target4 !== 2'd1) begin n_err++; $display("FAIL scan_down_target: got %0d expected 1", target4); end
        n_cmp++; if (tv4 !== 1'b1) begin n_err++; $display("FAIL scan_down_tv: got %b expected 1", tv4); end
        n_cmp++; if (dir4 !== 1'b0) begin n_err++; $display("FAIL scan_down_dir: got %b expected 0", dir4); end
        cur = 2'd1; done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL scan_done1: got %b expected 0000", floor4); end
        tick();
        n_cmp++; if (dir4 !== 1'b0) begin n_err++; $display("FAIL idle_dir_hold: got %b expected 0", dir4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL idle_tv: got %b expected 0", tv4); end
    endtask

    task automatic test_done_key_held();
        cur = 2'd1; key = 4'b0010;
        tick();
        tick();
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL held_dir_up: got %b expected 1", dir4); end
        n_cmp++; if (target4 !== 2'd1) begin n_err++; $display("FAIL held_own_floor: got %0d expected 1", target4); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL held_clear: got %b expected 0000", floor4); end
        tick();
        n_cmp++; if (floor4 !== 4'b0010) begin n_err++; $display("FAIL held_reset: got %b expected 0010", floor4); end
        key = 4'b0000; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_cur_floor_comb();
        cur = 2'd1; key = 4'b0101;
        tick();
        key = 4'b0000;
        tick();
        n_cmp++; if (target4 !== 2'd2) begin n_err++; $display("FAIL comb_above: got %0d expected 2", target4); end
        cur = 2'd0;
        #1;
        n_cmp++; if (target4 !== 2'd0) begin n_err++; $display("FAIL comb_cur_change: got %0d expected 0", target4); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (target4 !== 2'd2) begin n_err++; $display("FAIL comb_next: got %0d expected 2", target4); end
        cur = 2'd2; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_travel();
        cur = 2'd3; key = 4'b0111;
        tick();
        key = 4'b0000;
        tick();
        n_cmp++; if (dir4 !== 1'b0) begin n_err++; $display("FAIL mid_dir_down: got %b expected 0", dir4); end
        n_cmp++; if (target4 !== 2'd2) begin n_err++; $display("FAIL mid_target: got %0d expected 2", target4); end
        n_cmp++; if (floor4 !== 4'b0111) begin n_err++; $display("FAIL mid_floor: got %b expected 0111", floor4); end
        rst = 1'b1; done = 1'b1; key = 4'b1000;
        tick();
        rst = 1'b0; done = 1'b0; key = 4'b0000;
        n_cmp++; if (floor4 !== 4'b0000) begin n_err++; $display("FAIL mid_rst_floor: got %b expected 0000", floor4); end
        n_cmp++; if (dir4 !== 1'b1) begin n_err++; $display("FAIL mid_rst_dir: got %b expected 1", dir4); end
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL mid_rst_tv: got %b expected 0", tv4); end
        tick();
        n_cmp++; if (tv4 !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got %b expected 0", tv4); end
    endtask

    task automatic test_three_floors();
        int served [8];
        int nserv;
        cur3 = 2'd0; key3 = 3'b101;
        tick();
        key3 = 3'b000;
        n_cmp++; if (floor3 !== 3'b101) begin n_err++; $display("FAIL n3_latch: got %b expected 101", floor3); end
        cur3 = 2'd3; done3 = 1'b1;
        tick();
        done3 = 1'b0;
        n_cmp++; if (floor3 !== 3'b101) begin n_err++; $display("FAIL n3_oob_done: got %b expected 101", floor3); end
        // clear the leftovers and return to idle
        cur3 = 2'd0; done3 = 1'b1; tick();
        cur3 = 2'd2; tick();
        done3 = 1'b0; tick(); tick();
        // sweep: start at floor 1 with every floor requested
        cur3 = 2'd1; key3 = 3'b111;
        tick();
        key3 = 3'b000;
        tick();
        nserv = 0;
        for (int n = 0; n < 20 && floor3 != 3'b000; n++) begin
            if (tv3) begin
                if (nserv < 8) served[nserv] = int'(target3);
                nserv++;
                cur3 = target3; done3 = 1'b1;
                tick();
                done3 = 1'b0;
            end else begin
                tick();
            end
        end
        n_cmp++; if (nserv !== 3) begin n_err++; $display("FAIL sweep_count: got %0d expected 3", nserv); end
        n_cmp++; if (served[0] !== 1) begin n_err++; $display("FAIL sweep_stop0: got %0d expected 1", served[0]); end
        n_cmp++; if (served[1] !== 2) begin n_err++; $display("FAIL sweep_stop1: got %0d expected 2", served[1]); end
        n_cmp++; if (served[2] !== 0) begin n_err++; $display("FAIL sweep_stop2: got %0d expected 0", served[2]); end
        n_cmp++; if (dir3 !== 1'b0) begin n_err++; $display("FAIL sweep_dir: got %b expected 0", dir3); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; key = '0; done = 1'b0; cur = '0;
        key3 = '0; done3 = 1'b0; cur3 = '0;
        test_reset();
        test_single_key();
        test_scan_reverse();
        test_done_key_held();
        test_cur_floor_comb();
        test_reset_mid_travel();
        test_three_floors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_floor_scheduler
`default_nettype wire

// File: doc/floor_scheduler.md
# floor_scheduler

Parametrised request latch and SCAN scheduler for an N-floor elevator. Latches one pending request per floor from the button inputs and clears a floor's request when the car reports service there. Keeps travel direction and presents the next floor the car must stop at. Sits between the keypad inputs and the car-motion controller, replacing one single-floor request latch per floor.

## Interface
- NUM_FLOORS, default 4, number of floors (≥2); floor indices 0..NUM_FLOORS-1.
- FLOOR_W, localparam = $clog2(NUM_FLOORS), width of floor indices.

- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- KEY  in  NUM_FLOORS  request buttons, level-sensitive; bit i = floor i; any number may be high together.
- Done  in  1  one-cycle pulse: car has serviced floor cur_floor.
- cur_floor  in  FLOOR_W  current car position, driven by the motion controller.
- floor  out  NUM_FLOORS  latched pending requests; bit i = floor i pending.
- target  out  FLOOR_W  next stop; meaningful only when target_valid is high.
- target_valid  out  1  a stop exists in the current travel direction.
- dir  out  1  1 = up, 0 = down; holds its last value while idle.

## Operation
- Request register, per floor i, evaluated every cycle:
  - Clear when Done && cur_floor == i.
  - Otherwise set when KEY[i].
  - Otherwise hold.
  - Clear wins over a simultaneous KEY[i]. A key still held re-sets the bit on the following edge.
- Done with cur_floor ≥ NUM_FLOORS (non-power-of-two N) clears nothing.
- floor is the request register directly.
- Seek terms, combinational from the request register (req) and cur_floor:
  - above = lowest i ≥ cur_floor with req[i]; above_hit = such i exists.
  - below = highest i ≤ cur_floor with req[i]; below_hit = such i exists.
- Direction FSM, states IDLE, UP, DOWN, registered:
  - IDLE: if above_hit, go to UP. Else if any req, go to DOWN. Else stay IDLE.
  - UP: if above_hit, stay UP. Else if any req, go to DOWN. Else go to IDLE.
  - DOWN: if below_hit, stay DOWN. Else if any req, go to UP. Else go to IDLE.
- Outputs (combinational from registered state, req and cur_floor):
  - UP: target = above, target_valid = above_hit.
  - DOWN: target = below, target_valid = below_hit.
  - IDLE: target_valid = 0, target = 0.
  - dir is a register: set to 1 on entering UP, 0 on entering DOWN, otherwise held.
- A request at cur_floor counts as both above and below, so the car serves its own floor before moving.

## Timing
- Reset values: floor = 0, FSM = IDLE, dir = 1, target = 0, target_valid = 0.
- Reset wins over KEY and Done in the same cycle. Reset asserted mid-travel drops all pending requests.
- KEY[i] sampled at edge k gives floor[i] = 1 after edge k.
- FSM decisions use the request register value before edge k. Consequences:
  - From IDLE, the first target_valid appears after edge k+1 (2-cycle latency from key to target).
  - Already in UP/DOWN, a new request in the travel direction can change target after edge k (1 cycle).
- Done at edge k gives floor[cur_floor] = 0 after edge k. A direction reversal, if required, takes effect after edge k+1.
- cur_floor changes take effect combinationally on target. No registering.
- No handshake on target. The consumer re-reads target every cycle.

## Structure
- Shared package elevator_pkg holds:
  - typedef enum logic [1:0] {IDLE, UP, DOWN} dir_state_t;
  - the DIR_UP = 1'b1 and DIR_DOWN = 1'b0 constants.
- Sub-module floor_seek, parametrised by NUM_FLOORS, is purely combinational. It takes req and cur_floor and produces above, above_hit, below and below_hit. It is instantiated once.
- The request register and FSM stay in floor_scheduler.

## Test plan
- Reset with KEY = 4'b1111 held → floor = 0, target_valid = 0, dir = 1. Release reset with KEY = 0 → all stay 0.
- cur_floor = 0, pulse KEY = 4'b0100 for one cycle:
  - floor = 4'b0100 after 1 edge.
  - target = 2, target_valid = 1, dir = 1 after 2 edges.
- Requests 4'b1010, cur_floor = 2, FSM in UP → target = 3. Done at cur_floor = 3 → floor = 4'b0010, then FSM goes to DOWN, target = 1, dir = 0.
- Done with cur_floor = 1 while KEY[1] is held → floor[1] = 0 for exactly one cycle, then 1 again.
- NUM_FLOORS = 3 build, Done with cur_floor = 3 → floor unchanged. All-floor sweep up then down serves every floor exactly once.
- Reset asserted while in DOWN with floor = 4'b0111 → next cycle floor = 0, FSM = IDLE, dir = 1, target_valid = 0.
